// File: rtl/async_hs_bridge.sv
// Bridges clocked valid/ready token and result streams to a four-phase async stage (left req/ack, right req/ack).
// Latency: o_reqL rises the cycle after token accept; a result is captured SYNC_STAGES+1 cycles after i_reqR rises.
// Backpressure: o_tok_ready is low for a whole TX handshake; a stalled sink holds o_ackR low, so no result is lost.
module async_hs_bridge #(
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_tok_valid,
    output logic       o_tok_ready,
    input  logic [3:0] i_tok_data,
    output logic       o_reqL,
    output logic [3:0] o_data_l,
    input  logic       i_ackL,
    input  logic       i_reqR,
    input  logic [3:0] i_light,
    output logic       o_ackR,
    output logic       o_res_valid,
    input  logic       i_res_ready,
    output logic [3:0] o_res_data,
    output logic       o_timeout,
    output logic       o_busy
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT);

    typedef enum logic [1:0] {T_IDLE, T_REQ, T_REL} tx_state_t;
    typedef enum logic [1:0] {R_IDLE, R_HOLD, R_ACK, R_REL} rx_state_t;

    tx_state_t t_state, t_next;
    rx_state_t r_state, r_next;

    logic [SYNC_STAGES-1:0] ackl_sync, reqr_sync;
    logic                   ackl_s, reqr_s;
    logic [CW-1:0]          tx_cnt, rx_cnt;
    logic                   tx_inc, rx_inc;

    assign ackl_s = ackl_sync[SYNC_STAGES-1];
    assign reqr_s = reqr_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ackl_sync <= '0;
            reqr_sync <= '0;
        end else begin
            ackl_sync <= {ackl_sync[SYNC_STAGES-2:0], i_ackL};
            reqr_sync <= {reqr_sync[SYNC_STAGES-2:0], i_reqR};
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            t_state <= T_IDLE;
            r_state <= R_IDLE;
        end else begin
            t_state <= t_next;
            r_state <= r_next;
        end
    end

    always_comb begin
        t_next      = t_state;
        o_tok_ready = 1'b0;
        o_reqL      = 1'b0;
        case (t_state)
            T_IDLE: begin
                // Gated by reset so every output reads 0 while reset is held.
                o_tok_ready = !i_rst;
                if (i_tok_valid) t_next = T_REQ;
            end
            T_REQ: begin
                o_reqL = 1'b1;
                if (ackl_s) t_next = T_REL;
            end
            T_REL: begin
                if (!ackl_s) t_next = T_IDLE;
            end
            default: t_next = T_IDLE;
        endcase
    end

    always_comb begin
        r_next      = r_state;
        o_res_valid = 1'b0;
        o_ackR      = 1'b0;
        case (r_state)
            R_IDLE: if (reqr_s) r_next = R_HOLD;
            R_HOLD: begin
                o_res_valid = 1'b1;
                if (i_res_ready) r_next = R_ACK;
            end
            R_ACK: begin
                o_ackR = 1'b1;
                if (!reqr_s) r_next = R_REL;
            end
            R_REL:   r_next = R_IDLE;
            default: r_next = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_data_l   <= '0;
            o_res_data <= '0;
        end else begin
            if (t_state == T_IDLE && i_tok_valid) o_data_l <= i_tok_data;
            if (r_state == R_IDLE && reqr_s) o_res_data <= i_light;
        end
    end

    // Counters saturate at TO_MAX; with TIMEOUT=0 they never leave zero, disabling the pulse.
    assign tx_inc = (t_state != T_IDLE) && (t_next == t_state) && (tx_cnt != TO_MAX);
    assign rx_inc = (r_state == R_ACK) && (r_next == r_state) && (rx_cnt != TO_MAX);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tx_cnt    <= '0;
            rx_cnt    <= '0;
            o_timeout <= 1'b0;
        end else begin
            if (t_next != t_state) tx_cnt <= '0;
            else if (tx_inc)       tx_cnt <= tx_cnt + 1'b1;
            if (r_next != r_state) rx_cnt <= '0;
            else if (rx_inc)       rx_cnt <= rx_cnt + 1'b1;
            o_timeout <= (tx_inc && tx_cnt == TO_MAX - 1'b1) ||
                         (rx_inc && rx_cnt == TO_MAX - 1'b1);
        end
    end

    assign o_busy = (t_state != T_IDLE) || (r_state != R_IDLE);

endmodule
